segre_mem_arbiter: RTL and testbench

- Shares the single main-memory port between three requesters: instruction-cache line fills, data-cache line fills, and data-cache dirty-line writebacks.
- Sequences each transaction: grant, memory handshake, one-cycle fill/done pulse.
- Supplies the fill line and the replacement index to the requesting cache's tag/data arrays.
- Sits between the IF/MEM stage cache controllers and the memory model/bus.

---
 rtl/segre_pkg.sv | 24 ++
 rtl/segre_repl_counter.sv | 27 ++
 rtl/segre_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_segre_mem_arbiter.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// Shared types and constants for the segre core.
// Memory-arbiter states and requester ids live here too.
package segre_pkg;

  localparam int ADDR_SIZE         = 32;
  localparam int ICACHE_LANE_SIZE  = 128;
  localparam int ICACHE_INDEX_SIZE = 2;
  localparam int DCACHE_LANE_SIZE  = 128;
  localparam int DCACHE_INDEX_SIZE = 2;
  localparam int LINE_BYTE_BITS    = 4;

  typedef enum logic [1:0] {
    MA_IDLE,
    MA_MEM_WAIT,
    MA_RESP
  } mem_arb_state_e;

  typedef enum logic [1:0] {
    MA_IC,
    MA_DC,
    MA_WB
  } mem_arb_req_e;

endpackage

// File: rtl/segre_repl_counter.sv
// Wrapping replacement-index counter.
// Advances by one on each enabled cycle, rolling over at 2^WIDTH.
module segre_repl_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/segre_mem_arbiter.sv
// Main-memory port arbiter: icache fills, dcache fills, dcache writebacks.
// Writebacks win; fills share round-robin; one transaction at a time.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int ADDR_SIZE_P   = ADDR_SIZE,
  parameter int LANE_SIZE     = ICACHE_LANE_SIZE,
  parameter int IC_INDEX_SIZE = ICACHE_INDEX_SIZE,
  parameter int DC_INDEX_SIZE = DCACHE_INDEX_SIZE
) (
  input  logic                     clk_i,
  input  logic                     rsn_i,
  input  logic                     ic_miss_i,
  input  logic [ADDR_SIZE_P-1:0]   ic_addr_i,
  output logic                     ic_fill_o,
  output logic [LANE_SIZE-1:0]     ic_fill_data_o,
  output logic [IC_INDEX_SIZE-1:0] ic_lru_index_o,
  input  logic                     dc_miss_i,
  input  logic [ADDR_SIZE_P-1:0]   dc_addr_i,
  output logic                     dc_fill_o,
  output logic [LANE_SIZE-1:0]     dc_fill_data_o,
  output logic [DC_INDEX_SIZE-1:0] dc_lru_index_o,
  input  logic                     dc_wb_i,
  input  logic [ADDR_SIZE_P-1:0]   dc_wb_addr_i,
  input  logic [LANE_SIZE-1:0]     dc_wb_data_i,
  output logic                     dc_wb_done_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDR_SIZE_P-1:0]   mem_addr_o,
  output logic [LANE_SIZE-1:0]     mem_wr_data_o,
  input  logic                     mem_ready_i,
  input  logic [LANE_SIZE-1:0]     mem_rd_data_i
);

  mem_arb_state_e state_q, state_d;
  mem_arb_req_e   req_q, req_d;

  logic                   last_dc_q, last_dc_d;
  logic                   resp_q;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_SIZE_P-1:0] mem_addr_q, mem_addr_d;
  logic [LANE_SIZE-1:0]   mem_wd_q, mem_wd_d;
  logic [LANE_SIZE-1:0]   rd_data_q, rd_data_d;

  logic ic_ok, dc_ok, wb_ok;
  logic in_resp;

  // The requester served last is ignored for one IDLE cycle after its pulse.
  assign ic_ok = ic_miss_i & ~(resp_q & (req_q == MA_IC));
  assign dc_ok = dc_miss_i & ~(resp_q & (req_q == MA_DC));
  assign wb_ok = dc_wb_i   & ~(resp_q & (req_q == MA_WB));

  assign in_resp = (state_q == MA_RESP);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    last_dc_d = last_dc_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d  = mem_wd_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      MA_IDLE: begin
        unique case (1'b1)
          wb_ok: begin
            req_d      = MA_WB;
            mem_we_d   = 1'b1;
            mem_addr_d = dc_wb_addr_i;
            mem_wd_d   = dc_wb_data_i;
          end
          ~wb_ok & ic_ok & (~dc_ok | last_dc_q): begin
            req_d      = MA_IC;
            mem_we_d   = 1'b0;
            mem_addr_d = ic_addr_i;
            mem_wd_d   = '0;
          end
          ~wb_ok & dc_ok & (~ic_ok | ~last_dc_q): begin
            req_d      = MA_DC;
            mem_we_d   = 1'b0;
            mem_addr_d = dc_addr_i;
            mem_wd_d   = '0;
          end
          default: ;
        endcase
        if (wb_ok | ic_ok | dc_ok) begin
          mem_addr_d[LINE_BYTE_BITS-1:0] = '0;
          mem_req_d = 1'b1;
          state_d   = MA_MEM_WAIT;
        end
      end
      MA_MEM_WAIT: begin
        if (mem_ready_i) begin
          rd_data_d = mem_rd_data_i;
          mem_req_d = 1'b0;
          state_d   = MA_RESP;
        end
      end
      MA_RESP: begin
        state_d = MA_IDLE;
        if (req_q != MA_WB) last_dc_d = (req_q == MA_DC);
      end
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= MA_IDLE;
      req_q      <= MA_IC;
      last_dc_q  <= 1'b1;
      resp_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      last_dc_q  <= last_dc_d;
      resp_q     <= in_resp;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      rd_data_q  <= rd_data_d;
    end
  end

  segre_repl_counter #(.WIDTH(IC_INDEX_SIZE)) u_ic_cnt (
    .clk_i (clk_i),
    .rsn_i (rsn_i),
    .en_i  (in_resp & (req_q == MA_IC)),
    .cnt_o (ic_lru_index_o)
  );

  segre_repl_counter #(.WIDTH(DC_INDEX_SIZE)) u_dc_cnt (
    .clk_i (clk_i),
    .rsn_i (rsn_i),
    .en_i  (in_resp & (req_q == MA_DC)),
    .cnt_o (dc_lru_index_o)
  );

  assign ic_fill_o      = in_resp & (req_q == MA_IC);
  assign dc_fill_o      = in_resp & (req_q == MA_DC);
  assign dc_wb_done_o   = in_resp & (req_q == MA_WB);
  assign ic_fill_data_o = rd_data_q;
  assign dc_fill_data_o = rd_data_q;
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wr_data_o  = mem_wd_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Self-checking bench for segre_mem_arbiter.
// Directed scenarios plus a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_segre_mem_arbiter;

  logic         clk_i = 1'b0;
  logic         rsn_i = 1'b0;
  logic         ic_miss_i = 1'b0;
  logic [31:0]  ic_addr_i = '0;
  logic         ic_fill_o;
  logic [127:0] ic_fill_data_o;
  logic [1:0]   ic_lru_index_o;
  logic         dc_miss_i = 1'b0;
  logic [31:0]  dc_addr_i = '0;
  logic         dc_fill_o;
  logic [127:0] dc_fill_data_o;
  logic [1:0]   dc_lru_index_o;
  logic         dc_wb_i = 1'b0;
  logic [31:0]  dc_wb_addr_i = '0;
  logic [127:0] dc_wb_data_i = '0;
  logic         dc_wb_done_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wr_data_o;
  logic         mem_ready_i = 1'b0;
  logic [127:0] mem_rd_data_i = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic         t_ok;
  logic         t_we;
  logic [31:0]  t_a;
  logic [127:0] t_wd;
  logic [2:0]   t_p;
  logic [127:0] t_fi;
  logic [127:0] t_fd;
  logic [1:0]   t_li;
  logic [1:0]   t_ld;

  segre_mem_arbiter dut (
    .clk_i          (clk_i),
    .rsn_i          (rsn_i),
    .ic_miss_i      (ic_miss_i),
    .ic_addr_i      (ic_addr_i),
    .ic_fill_o      (ic_fill_o),
    .ic_fill_data_o (ic_fill_data_o),
    .ic_lru_index_o (ic_lru_index_o),
    .dc_miss_i      (dc_miss_i),
    .dc_addr_i      (dc_addr_i),
    .dc_fill_o      (dc_fill_o),
    .dc_fill_data_o (dc_fill_data_o),
    .dc_lru_index_o (dc_lru_index_o),
    .dc_wb_i        (dc_wb_i),
    .dc_wb_addr_i   (dc_wb_addr_i),
    .dc_wb_data_i   (dc_wb_data_i),
    .dc_wb_done_o   (dc_wb_done_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .mem_ready_i    (mem_ready_i),
    .mem_rd_data_i  (mem_rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [2:0] pulses();
    return {dc_wb_done_o, dc_fill_o, ic_fill_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rsn_i = 1'b0;
    ic_miss_i = 1'b0;
    dc_miss_i = 1'b0;
    dc_wb_i = 1'b0;
    mem_ready_i = 1'b0;
    mem_rd_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rsn_i = 1'b1;
  endtask

  // Waits for mem_req_o, answers after lat cycles, returns what was seen.
  task automatic do_txn(input int lat, input logic [127:0] d);
    t_ok = 1'b0;
    for (int i = 0; i < 20 && !t_ok; i++) begin
      if (mem_req_o) t_ok = 1'b1;
      else tick();
    end
    t_p = '0;
    if (!t_ok) return;
    t_we = mem_we_o;
    t_a  = mem_addr_o;
    t_wd = mem_wr_data_o;
    repeat (lat) tick();
    mem_rd_data_i = d;
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    mem_rd_data_i = '0;
    t_p  = pulses();
    t_fi = ic_fill_data_o;
    t_fd = dc_fill_data_o;
    t_li = ic_lru_index_o;
    t_ld = dc_lru_index_o;
  endtask

  task automatic test_reset();
    rsn_i = 1'b0;
    #2;
    n_cmp++;
    if ({mem_req_o, mem_we_o, pulses()} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 0", {mem_req_o, mem_we_o, pulses()});
    end
    n_cmp++;
    if ({mem_addr_o, mem_wr_data_o} !== '0) begin
      n_err++;
      $display("FAIL reset_mem: got %h want 0", {mem_addr_o, mem_wr_data_o});
    end
    n_cmp++;
    if ({ic_lru_index_o, dc_lru_index_o, ic_fill_data_o, dc_fill_data_o} !== '0) begin
      n_err++;
      $display("FAIL reset_fill: got nonzero fill/lru outputs, want 0");
    end
  endtask

  task automatic test_single_ic();
    logic [127:0] d;
    d = rnd128();
    do_reset();
    ic_miss_i = 1'b1;
    ic_addr_i = 32'h0000_104C;
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_lat: mem_req_o got %b want 1", mem_req_o);
    end
    do_txn(4, d);
    ic_miss_i = 1'b0;
    n_cmp++;
    if ({t_ok, t_we, t_a} !== {1'b1, 1'b0, 32'h0000_1040}) begin
      n_err++;
      $display("FAIL single_req: ok/we/addr got %b/%b/%h want 1/0/00001040", t_ok, t_we, t_a);
    end
    n_cmp++;
    if ({t_p, t_li, t_fi} !== {3'b001, 2'd0, d}) begin
      n_err++;
      $display("FAIL single_fill: pulse %b lru %0d data %h want 001 0 %h", t_p, t_li, t_fi, d);
    end
    n_cmp++;
    if (mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_drop: mem_req_o got %b want 0", mem_req_o);
    end
    tick();
    n_cmp++;
    if (pulses() !== 3'b000) begin
      n_err++;
      $display("FAIL single_onepulse: got %b want 000", pulses());
    end
  endtask

  task automatic test_tie();
    logic [127:0] d;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      ic_miss_i = 1'b1;
      dc_miss_i = 1'b1;
      ic_addr_i = 32'h0000_2010 + 32'(r * 64);
      dc_addr_i = 32'h0000_3024 + 32'(r * 64);
      d = rnd128();
      do_txn(1, d);
      ic_miss_i = 1'b0;
      n_cmp++;
      if ({t_ok, t_p, t_a, t_fi} !== {1'b1, 3'b001, 32'h0000_2010 + 32'(r * 64), d}) begin
        n_err++;
        $display("FAIL tie_first r%0d: ok %b pulse %b addr %h want 1 001 ic", r, t_ok, t_p, t_a);
      end
      d = rnd128();
      do_txn(0, d);
      dc_miss_i = 1'b0;
      n_cmp++;
      if ({t_ok, t_p, t_a, t_fd} !== {1'b1, 3'b010, 32'h0000_3020 + 32'(r * 64), d}) begin
        n_err++;
        $display("FAIL tie_second r%0d: ok %b pulse %b addr %h want 1 010 dc", r, t_ok, t_p, t_a);
      end
      tick();
      tick();
    end
  endtask

  task automatic test_wb_priority();
    logic [127:0] wbd;
    logic [127:0] d;
    wbd = rnd128();
    do_reset();
    dc_wb_i = 1'b1;
    dc_miss_i = 1'b1;
    ic_miss_i = 1'b1;
    dc_wb_addr_i = 32'h0000_200C;
    dc_wb_data_i = wbd;
    dc_addr_i = 32'h0000_5000;
    ic_addr_i = 32'h0000_6004;
    do_txn(2, rnd128());
    dc_wb_i = 1'b0;
    dc_wb_data_i = rnd128();
    n_cmp++;
    if ({t_ok, t_we, t_a, t_wd, t_p} !== {1'b1, 1'b1, 32'h0000_2000, wbd, 3'b100}) begin
      n_err++;
      $display("FAIL wb_first: ok %b we %b addr %h wd %h pulse %b", t_ok, t_we, t_a, t_wd, t_p);
    end
    d = rnd128();
    do_txn(0, d);
    ic_miss_i = 1'b0;
    n_cmp++;
    if ({t_ok, t_we, t_a, t_p, t_fi} !== {1'b1, 1'b0, 32'h0000_6000, 3'b001, d}) begin
      n_err++;
      $display("FAIL wb_then_ic: ok %b we %b addr %h pulse %b", t_ok, t_we, t_a, t_p);
    end
    d = rnd128();
    do_txn(3, d);
    dc_miss_i = 1'b0;
    n_cmp++;
    if ({t_ok, t_we, t_a, t_wd, t_p, t_fd} !== {1'b1, 1'b0, 32'h0000_5000, 128'h0, 3'b010, d}) begin
      n_err++;
      $display("FAIL wb_then_dc: ok %b we %b addr %h pulse %b", t_ok, t_we, t_a, t_p);
    end
    tick();
  endtask

  task automatic test_lru_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ic_miss_i = 1'b1;
      ic_addr_i = $urandom;
      do_txn(i % 3, rnd128());
      ic_miss_i = 1'b0;
      n_cmp++;
      if ({t_ok, t_p, t_li, t_ld} !== {1'b1, 3'b001, 2'(i % 4), 2'd0}) begin
        n_err++;
        $display("FAIL lru_wrap i%0d: ok %b pulse %b ic_lru %0d dc_lru %0d want %0d 0", i, t_ok, t_p, t_li, t_ld, i % 4);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] seen;
    logic [127:0] d;
    do_reset();
    ic_miss_i = 1'b1;
    ic_addr_i = 32'h0000_7000;
    tick();
    tick();
    tick();
    do_txn(0, rnd128());
    ic_miss_i = 1'b0;
    ic_miss_i = 1'b1;
    tick();
    tick();
    rsn_i = 1'b0;
    ic_miss_i = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req_o, mem_we_o, pulses(), mem_addr_o, ic_lru_index_o} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_out: req %b addr %h lru %0d want 0", mem_req_o, mem_addr_o, ic_lru_index_o);
    end
    seen = '0;
    tick();
    mem_ready_i = 1'b1;
    mem_rd_data_i = rnd128();
    tick();
    seen |= pulses();
    mem_ready_i = 1'b0;
    rsn_i = 1'b1;
    tick();
    seen |= pulses();
    mem_ready_i = 1'b1;
    tick();
    seen |= pulses();
    mem_ready_i = 1'b0;
    tick();
    seen |= pulses();
    n_cmp++;
    if ({seen, mem_req_o} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_mid_nopulse: pulses %b req %b want 0", seen, mem_req_o);
    end
    n_cmp++;
    if ({ic_lru_index_o, dc_lru_index_o} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_mid_cnt: ic %0d dc %0d want 0 0", ic_lru_index_o, dc_lru_index_o);
    end
    d = rnd128();
    ic_miss_i = 1'b1;
    ic_addr_i = 32'h0000_300F;
    do_txn(1, d);
    ic_miss_i = 1'b0;
    n_cmp++;
    if ({t_ok, t_a, t_p, t_li, t_fi} !== {1'b1, 32'h0000_3000, 3'b001, 2'd0, d}) begin
      n_err++;
      $display("FAIL rst_mid_next: ok %b addr %h pulse %b lru %0d", t_ok, t_a, t_p, t_li);
    end
    tick();
  endtask

  task automatic test_stale_mask();
    do_reset();
    ic_miss_i = 1'b1;
    ic_addr_i = 32'h0000_8040;
    do_txn(0, rnd128());
    n_cmp++;
    if ({t_ok, t_p} !== {1'b1, 3'b001}) begin
      n_err++;
      $display("FAIL stale_fill: ok %b pulse %b want 1 001", t_ok, t_p);
    end
    tick();
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL stale_mask: mem_req_o got %b want 0", mem_req_o);
    end
    ic_miss_i = 1'b0;
    tick();
    n_cmp++;
    if ({mem_req_o, pulses()} !== 4'b0) begin
      n_err++;
      $display("FAIL stale_after: req %b pulse %b want 0", mem_req_o, pulses());
    end
  endtask

  // Random traffic checked against a transaction-level model of the arbiter.
  task automatic test_random();
    bit           lvl[3];
    bit           in_prev[3];
    bit           hold[3];
    bit           c[3];
    logic [31:0]  ra[3];
    logic [127:0] wbd, rdd, ewd;
    logic [31:0]  ea;
    logic         ewe;
    logic [2:0]   op, ep;
    int           last_fill, cnt_ic, cnt_dc;
    int           pid_prev, pid_prev2, cur_pid;
    int           exp_id, wait_cnt, w;
    bit           in_txn, ready_pend;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      lvl[i] = 0;
      in_prev[i] = 0;
      hold[i] = 0;
      ra[i] = $urandom;
    end
    wbd = rnd128();
    rdd = '0;
    ea = '0;
    ewe = 1'b0;
    ewd = '0;
    last_fill = 1;
    cnt_ic = 0;
    cnt_dc = 0;
    pid_prev = -1;
    pid_prev2 = -1;
    exp_id = 0;
    wait_cnt = 0;
    in_txn = 0;
    ready_pend = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      cur_pid = -1;
      op = pulses();
      if (ready_pend) begin
        ep = 3'b001 << exp_id;
        n_cmp++;
        if ({op, mem_req_o} !== {ep, 1'b0}) begin
          n_err++;
          $display("FAIL rnd_pulse c%0d: pulse %b req %b want %b 0", cyc, op, mem_req_o, ep);
        end
        if (exp_id == 0) begin
          n_cmp++;
          if ({ic_fill_data_o, ic_lru_index_o} !== {rdd, 2'(cnt_ic)}) begin
            n_err++;
            $display("FAIL rnd_icfill c%0d: lru %0d data %h want %0d %h", cyc, ic_lru_index_o, ic_fill_data_o, cnt_ic, rdd);
          end
          cnt_ic = (cnt_ic + 1) % 4;
          last_fill = 0;
        end else if (exp_id == 1) begin
          n_cmp++;
          if ({dc_fill_data_o, dc_lru_index_o} !== {rdd, 2'(cnt_dc)}) begin
            n_err++;
            $display("FAIL rnd_dcfill c%0d: lru %0d data %h want %0d %h", cyc, dc_lru_index_o, dc_fill_data_o, cnt_dc, rdd);
          end
          cnt_dc = (cnt_dc + 1) % 4;
          last_fill = 1;
        end
        cur_pid = exp_id;
        in_txn = 0;
        ready_pend = 0;
      end else begin
        n_cmp++;
        if (op !== 3'b000) begin
          n_err++;
          $display("FAIL rnd_nopulse c%0d: got %b want 000", cyc, op);
        end
        if (in_txn) begin
          n_cmp++;
          if ({mem_req_o, mem_we_o, mem_addr_o, mem_wr_data_o} !== {1'b1, ewe, ea, ewd}) begin
            n_err++;
            $display("FAIL rnd_hold c%0d: req %b we %b addr %h want 1 %b %h", cyc, mem_req_o, mem_we_o, mem_addr_o, ewe, ea);
          end
        end else if (pid_prev < 0) begin
          for (int i = 0; i < 3; i++) c[i] = in_prev[i] && (pid_prev2 != i);
          if (c[2]) w = 2;
          else if (c[0] && c[1]) w = (last_fill == 1) ? 0 : 1;
          else if (c[0]) w = 0;
          else if (c[1]) w = 1;
          else w = -1;
          n_cmp++;
          if (mem_req_o !== (w >= 0)) begin
            n_err++;
            $display("FAIL rnd_grant c%0d: req %b want %b (winner %0d)", cyc, mem_req_o, w >= 0, w);
          end else if (w >= 0) begin
            ea = {ra[w][31:4], 4'h0};
            ewe = (w == 2);
            ewd = (w == 2) ? wbd : '0;
            n_cmp++;
            if ({mem_we_o, mem_addr_o, mem_wr_data_o} !== {ewe, ea, ewd}) begin
              n_err++;
              $display("FAIL rnd_who c%0d: we %b addr %h want %b %h (winner %0d)", cyc, mem_we_o, mem_addr_o, ewe, ea, w);
            end
            in_txn = 1;
            exp_id = w;
            wait_cnt = $urandom_range(0, 4);
            ra[w] = $urandom;
            if (w == 2) wbd = rnd128();
          end
        end else begin
          n_cmp++;
          if (mem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL rnd_respidle c%0d: req %b want 0", cyc, mem_req_o);
          end
        end
      end
      if (in_txn) begin
        if (wait_cnt == 0) begin
          rdd = rnd128();
          mem_rd_data_i = rdd;
          mem_ready_i = 1'b1;
          ready_pend = 1;
        end else begin
          wait_cnt--;
          mem_ready_i = 1'b0;
          mem_rd_data_i = rnd128();
        end
      end else begin
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rd_data_i = rnd128();
      end
      for (int i = 0; i < 3; i++) begin
        if (lvl[i]) begin
          if (cur_pid == i) begin
            if ($urandom_range(0, 1) == 0) lvl[i] = 0;
            else hold[i] = 1;
          end else if (hold[i]) begin
            hold[i] = 0;
            lvl[i] = 0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          lvl[i] = 1;
          ra[i] = $urandom;
          if (i == 2) wbd = rnd128();
        end
      end
      ic_miss_i = lvl[0];
      ic_addr_i = ra[0];
      dc_miss_i = lvl[1];
      dc_addr_i = ra[1];
      dc_wb_i = lvl[2];
      dc_wb_addr_i = ra[2];
      dc_wb_data_i = wbd;
      in_prev = lvl;
      pid_prev2 = pid_prev;
      pid_prev = cur_pid;
    end
    mem_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_ic();
    test_tie();
    test_wb_priority();
    test_lru_wrap();
    test_reset_mid();
    test_stale_mask();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
